// File: rtl/voq_scheduler_if.sv
// ---------------------------------------------------------------------------
// voq_scheduler_if
//   Bundles the request side (sched_en, voq_req, egress_full) and the match
//   side (match_valid, match_grant, ingress_send, slot_done, busy) of the
//   crossbar scheduler into one connection.
//
//   Parameter:
//     N_PORTS      number of ingress/egress ports
//   Signals:
//     sched_en     scheduling enable (level), driven from the ctrl register
//     voq_req      bit [i*N_PORTS+j]: ingress i holds a cell for egress j
//     egress_full  bit j: egress j buffer full, masks column j
//     match_valid  match outputs valid for the current slot
//     match_grant  same layout as voq_req, at most one bit per row/column
//     ingress_send bit i: ingress i matched this slot
//     slot_done    one-cycle pulse on the last cycle of a slot
//     busy         scheduler is not idle
//   Modports:
//     master       requester side (ingress blocks / control)
//     slave        the scheduler itself
// ---------------------------------------------------------------------------
interface voq_scheduler_if #(
  parameter int N_PORTS = 4
);

  logic                           sched_en;
  logic [N_PORTS*N_PORTS-1:0]     voq_req;
  logic [N_PORTS-1:0]             egress_full;
  logic                           match_valid;
  logic [N_PORTS*N_PORTS-1:0]     match_grant;
  logic [N_PORTS-1:0]             ingress_send;
  logic                           slot_done;
  logic                           busy;

  modport master (
    output sched_en, voq_req, egress_full,
    input  match_valid, match_grant, ingress_send, slot_done, busy
  );

  modport slave (
    input  sched_en, voq_req, egress_full,
    output match_valid, match_grant, ingress_send, slot_done, busy
  );

endinterface

// File: rtl/voq_scheduler.sv
// ---------------------------------------------------------------------------
// voq_scheduler
//   Crossbar scheduler for the N-port switch. Each slot it latches the
//   eligible virtual-output-queue requests (columns of full egresses
//   removed), computes a conflict-free ingress->egress match with iSLIP
//   (round-robin grant, then round-robin accept), holds it for SLOT_CYCLES
//   clock cycles and then re-arbitrates.
//
//   Parameters:
//     N_PORTS      number of ingress and egress ports (power of 2, >= 2)
//     SLOT_CYCLES  clock cycles a match is held (>= 1)
//   Ports:
//     clk_i        system clock
//     rst_ni       asynchronous active-low reset
//     sched_if     voq_scheduler_if.slave (requests in, match out)
//
//   Build option:
//     SCHED_MULTI_ITER_EN  when defined, adds an ARB2 state that runs a
//                          second grant/accept iteration over the ports
//                          left unmatched by the first one. Pointers only
//                          move on first-iteration accepts.
// ---------------------------------------------------------------------------
module voq_scheduler #(
  parameter int N_PORTS     = 4,
  parameter int SLOT_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  voq_scheduler_if.slave   sched_if
);

  localparam int NN = N_PORTS * N_PORTS;
  localparam int PW = $clog2(N_PORTS);
  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  typedef logic [N_PORTS-1:0][PW-1:0]      ptr_vec_t;
  typedef logic [N_PORTS-1:0][N_PORTS-1:0] mat_t;

`ifdef SCHED_MULTI_ITER_EN
  typedef enum logic [1:0] {IDLE, ARB, ARB2, XFER} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;
`endif

  state_t        state_q;
  logic [NN-1:0] req_q;
  ptr_vec_t      g_ptr_q;
  ptr_vec_t      a_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          match_valid_q;
  logic [NN-1:0] match_grant_q;
  logic [N_PORTS-1:0] ingress_send_q;
  logic          slot_done_q;
  logic          busy_q;

  logic [NN-1:0] elig_d;
  logic [NN-1:0] match1_d;
  mat_t          match1_m;
`ifdef SCHED_MULTI_ITER_EN
  logic [NN-1:0] match2_d;
`endif

  // One iSLIP iteration: every egress grants the first requesting ingress
  // at/after its grant pointer, then every ingress accepts the first
  // granting egress at/after its accept pointer. Row index = ingress.
  function automatic logic [NN-1:0] islipMatch(input logic [NN-1:0] req,
                                               input ptr_vec_t   gPtr,
                                               input ptr_vec_t   aPtr);
    mat_t          reqM;
    mat_t          grantM;
    mat_t          matchM;
    logic          found;
    logic [PW-1:0] idx;
    reqM   = req;
    grantM = '0;
    matchM = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      found = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
        idx = gPtr[j] + PW'(k);
        if (!found && reqM[idx][j]) begin
          grantM[j][idx] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      found = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
        idx = aPtr[i] + PW'(k);
        if (!found && grantM[idx][i]) begin
          matchM[i][idx] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return matchM;
  endfunction

  function automatic logic [N_PORTS-1:0] rowOr(input logic [NN-1:0] m);
    mat_t               mM;
    logic [N_PORTS-1:0] r;
    mM = m;
    for (int i = 0; i < N_PORTS; i++) begin
      r[i] = |mM[i];
    end
    return r;
  endfunction

  // Full egress buffers knock out their whole column before latching.
  assign elig_d   = sched_if.voq_req & ~{N_PORTS{sched_if.egress_full}};
  assign match1_d = islipMatch(req_q, g_ptr_q, a_ptr_q);
  assign match1_m = match1_d;

`ifdef SCHED_MULTI_ITER_EN
  // Second iteration only sees rows and columns the first one left free.
  always_comb begin
    logic [N_PORTS-1:0] rowUsed;
    logic [N_PORTS-1:0] colUsed;
    mat_t               mask;
    mat_t               grantM;
    rowUsed = ingress_send_q;
    colUsed = '0;
    grantM  = match_grant_q;
    mask    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      colUsed = colUsed | grantM[i];
    end
    for (int i = 0; i < N_PORTS; i++) begin
      mask[i] = rowUsed[i] ? '0 : ~colUsed;
    end
    match2_d = islipMatch(req_q & mask, g_ptr_q, a_ptr_q);
  end
`endif

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      req_q          <= '0;
      g_ptr_q        <= '0;
      a_ptr_q        <= '0;
      cnt_q          <= '0;
      match_valid_q  <= 1'b0;
      match_grant_q  <= '0;
      ingress_send_q <= '0;
      slot_done_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          slot_done_q <= 1'b0;
          if (sched_if.sched_en && (|elig_d)) begin
            req_q   <= elig_d;
            state_q <= ARB;
            busy_q  <= 1'b1;
          end
        end

        ARB: begin
          match_grant_q  <= match1_d;
          ingress_send_q <= rowOr(match1_d);
          // Only accepted pairs move pointers, one past the partner.
          for (int i = 0; i < N_PORTS; i++) begin
            for (int j = 0; j < N_PORTS; j++) begin
              if (match1_m[i][j]) begin
                g_ptr_q[j] <= PW'(i + 1);
                a_ptr_q[i] <= PW'(j + 1);
              end
            end
          end
`ifdef SCHED_MULTI_ITER_EN
          state_q <= ARB2;
`else
          cnt_q         <= CW'(SLOT_CYCLES - 1);
          match_valid_q <= 1'b1;
          slot_done_q   <= (SLOT_CYCLES == 1);
          state_q       <= XFER;
`endif
        end

`ifdef SCHED_MULTI_ITER_EN
        ARB2: begin
          match_grant_q  <= match_grant_q | match2_d;
          ingress_send_q <= ingress_send_q | rowOr(match2_d);
          cnt_q          <= CW'(SLOT_CYCLES - 1);
          match_valid_q  <= 1'b1;
          slot_done_q    <= (SLOT_CYCLES == 1);
          state_q        <= XFER;
        end
`endif

        XFER: begin
          if (cnt_q == '0) begin
            state_q        <= IDLE;
            match_valid_q  <= 1'b0;
            match_grant_q  <= '0;
            ingress_send_q <= '0;
            slot_done_q    <= 1'b0;
            busy_q         <= 1'b0;
          end else begin
            cnt_q       <= cnt_q - CW'(1);
            slot_done_q <= (cnt_q == CW'(1));
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign sched_if.match_valid  = match_valid_q;
  assign sched_if.match_grant  = match_grant_q;
  assign sched_if.ingress_send = ingress_send_q;
  assign sched_if.slot_done    = slot_done_q;
  assign sched_if.busy         = busy_q;

endmodule
